// File: rtl/i2s_rx_multi.sv
// rtl/i2s_rx_multi.sv - Multi-line I2S / left-justified master receiver with word stream output
//
// Generates sclk_o/wsel_o from clk_i and deserialises LINES data lines per
// channel slot. Each completed set of words, tagged with its channel, moves
// into a holding bank. The bank drains one word per handshake on the
// data_o/valid_o/ready_i stream.
//
// Ports:
//   clk_i, rst_i            system clock, asynchronous active-high reset
//   en_i                    run enable for the serial engine (low = engine held in reset)
//   fmt_i                   0 = Philips I2S, 1 = left-justified
//   sdat_i[LINES]           serial data, bit n = line n
//   sclk_o, wsel_o          generated bit clock and word select (0 left, 1 right)
//   data_o, lr_chnl_o       received word and its channel
//   line_o, valid_o         source line of data_o, stream valid
//   ready_i                 consumer accepts the presented word
//   overrun_o, clr_ovr_i    sticky "undrained words dropped" flag and its clear
module i2s_rx_multi #(
    parameter int WORD_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_DIV   = 2,
    parameter int LINES      = 2,
    localparam int LW        = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  fmt_i,
    input  logic [LINES-1:0]      sdat_i,
    output logic                  sclk_o,
    output logic                  wsel_o,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  lr_chnl_o,
    output logic [LW-1:0]         line_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o,
    input  logic                  clr_ovr_i
);

    localparam int PW = $clog2(SLOT_WIDTH);
    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [PW-1:0] POS_LAST  = PW'(SLOT_WIDTH - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

    logic [CW-1:0]         div_cnt;
    logic [PW-1:0]         pos;
    logic                  fmt_q;
    logic [WORD_WIDTH-1:0] shreg     [LINES];
    logic [WORD_WIDTH-1:0] word_next [LINES];
    logic [WORD_WIDTH-1:0] bank      [LINES];
    logic                  bank_lr;
    logic [LW-1:0]         idx;

    logic          div_tc;
    logic          rise;
    logic          fall;
    logic [PW-1:0] first_pos;
    logic [PW-1:0] last_pos;
    logic          in_word;
    logic          load;
    logic          xfer;
    logic          final_xfer;

    always_comb begin
        div_tc     = (div_cnt == DIV_LAST);
        rise       = en_i & div_tc & ~sclk_o;
        fall       = en_i & div_tc & sclk_o;
        // Philips I2S delays the MSB by one bit clock after the wsel edge.
        first_pos  = fmt_q ? '0 : PW'(1);
        last_pos   = first_pos + PW'(WORD_WIDTH - 1);
        in_word    = rise && (pos >= first_pos) && (pos <= last_pos);
        load       = rise && (pos == last_pos);
        xfer       = valid_o & ready_i;
        final_xfer = xfer && (idx == LINE_LAST);
        for (int n = 0; n < LINES; n++) begin
            word_next[n] = (shreg[n] << 1) | WORD_WIDTH'(sdat_i[n]);
        end
    end

    // Serial engine: divider, bit clock, slot position, word select, shifters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
            pos     <= '0;
            wsel_o  <= 1'b0;
            fmt_q   <= 1'b0;
            for (int n = 0; n < LINES; n++) begin
                shreg[n] <= '0;
            end
        end else if (!en_i) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
            pos     <= '0;
            wsel_o  <= 1'b0;
            fmt_q   <= fmt_i;
            for (int n = 0; n < LINES; n++) begin
                shreg[n] <= '0;
            end
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) begin
                sclk_o <= ~sclk_o;
            end
            if (fall) begin
                if (pos == POS_LAST) begin
                    pos    <= '0;
                    wsel_o <= ~wsel_o;
                    // Format may only change at the start of a left slot so a
                    // frame is never split between two formats.
                    if (wsel_o) begin
                        fmt_q <= fmt_i;
                    end
                end else begin
                    pos <= pos + 1'b1;
                end
            end
            if (in_word) begin
                for (int n = 0; n < LINES; n++) begin
                    shreg[n] <= word_next[n];
                end
            end
        end
    end

    // Holding bank and output sequencer; keeps draining while en_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < LINES; n++) begin
                bank[n] <= '0;
            end
            bank_lr   <= 1'b0;
            idx       <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (load) begin
                for (int n = 0; n < LINES; n++) begin
                    bank[n] <= word_next[n];
                end
                bank_lr <= wsel_o;
                idx     <= '0;
                valid_o <= 1'b1;
            end else if (xfer) begin
                if (idx == LINE_LAST) begin
                    valid_o <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            // A load that lands on the final handshake of the old bank loses
            // nothing, so it is not an overrun.
            if (load && valid_o && !final_xfer) begin
                overrun_o <= 1'b1;
            end else if (clr_ovr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    assign data_o    = bank[idx];
    assign lr_chnl_o = bank_lr;
    assign line_o    = idx;

endmodule

// File: doc/i2s_rx_multi.md
# i2s_rx_multi

Parametrised I2S master receiver: generates `sclk_o`/`wsel_o` from `clk_i`, deserialises `LINES` parallel serial data lines in Philips-I2S or left-justified format, and presents each received word on a valid/ready stream. Successor to `i2s_top_rx`: adds configurable word/slot width, clock divider, multiple data lines, format select, backpressure and overrun detection. Sits between the audio pads and the sample FIFO/DSP path.

## Interface
- `WORD_WIDTH`, 16, bits captured per channel word; 1 ≤ WORD_WIDTH ≤ SLOT_WIDTH-1
- `SLOT_WIDTH`, 32, sclk periods per half-frame (one channel slot); ≥ 2
- `SCLK_DIV`, 2, clk_i cycles per sclk half-period; ≥ 1
- `LINES`, 2, number of serial data inputs; ≥ 1
- `clk_i` in 1: system clock
- `rst_i` in 1: reset, asynchronous, active-high
- `en_i` in 1: run enable; low holds the serial engine in its reset state
- `fmt_i` in 1: 0 = Philips I2S (MSB one sclk after wsel edge), 1 = left-justified (MSB on wsel edge)
- `sdat_i` in LINES: serial data, bit n = line n
- `sclk_o` out 1: serial bit clock
- `wsel_o` out 1: word select, 0 = left, 1 = right
- `data_o` out WORD_WIDTH: received word, MSB first on the wire
- `lr_chnl_o` out 1: channel of `data_o` (0 left, 1 right)
- `line_o` out max(1,clog2(LINES)): source line of `data_o`
- `valid_o` out 1: `data_o`/`lr_chnl_o`/`line_o` valid
- `ready_i` in 1: consumer accepts word
- `overrun_o` out 1: sticky, undrained words were dropped
- `clr_ovr_i` in 1: clears `overrun_o`

## Operation
- Reset values: `sclk_o`=0, `wsel_o`=0, `data_o`=0, `lr_chnl_o`=0, `line_o`=0, `valid_o`=0, `overrun_o`=0; divider, bit position, shift registers cleared.
- Divider counts 0..SCLK_DIV-1; at terminal count `sclk_o` toggles. sclk period = 2·SCLK_DIV clk_i cycles.
- Bit position `pos` 0..SLOT_WIDTH-1 advances on each sclk falling toggle; wrap to 0 toggles `wsel_o`. Frame = 2·SLOT_WIDTH sclk periods.
- Sampling: on the clk_i edge where `sclk_o` toggles 0→1, every line samples `sdat_i` into its shift register if `pos` ∈ [d, d+WORD_WIDTH-1], d = 1 (I2S) or 0 (LJ). Other positions ignored (padding).
- Format latch: `fmt_i` registered while `en_i`=0 and at each wrap into a left slot; never changes mid-frame.
- Bank load: at sampling of bit d+WORD_WIDTH-1, all LINES completed words plus current `wsel_o` copy into a holding bank; read index reset to 0.
- Output sequencer: presents bank words line 0..LINES-1; transfer on `valid_o & ready_i`; index increments; `valid_o` drops after last line transferred.
- Overrun: bank load while words remain undrained (excluding a final transfer in the same cycle) → old remainder discarded, new bank presented from line 0, `overrun_o`=1. Load coincident with final transfer of old bank is not overrun.
- `clr_ovr_i`=1 clears `overrun_o` next edge; a simultaneous new overrun wins (stays 1).
- `en_i`=0: divider, `pos`, `sclk_o`, `wsel_o`, shift registers return to reset values the next edge; partial words discarded; holding bank keeps draining. Re-enable starts at left slot, `pos`=0.

## Timing
- First sclk rise SCLK_DIV cycles after `en_i`=1 (rst released).
- `valid_o` rises 1 clk_i cycle after the edge sampling the word's LSB.
- `data_o`, `lr_chnl_o`, `line_o` stable while `valid_o`=1 and `ready_i`=0.
- With `ready_i` held 1, LINES words drain in LINES consecutive cycles.
- No overrun possible when drain time ≤ (SLOT_WIDTH-WORD_WIDTH)·2·SCLK_DIV + 2·SCLK_DIV·WORD_WIDTH cycles, i.e. consumer keeps one word/slot per line.
- Async `rst_i` mid-frame: all outputs immediately to reset values; bank contents lost.

## Test plan
- WORD=16, SLOT=17, DIV=1, LINES=1, I2S, ready=1: transmitter drives 0xA5C3 left, 0x3C5A right on sclk falls → data_o 0xA5C3 lr=0, then 0x3C5A lr=1; valid 1 cycle after LSB.
- Same, fmt_i=1 (LJ): MSB on wsel edge → same words recovered; mis-aligned I2S stimulus yields words shifted by one bit (checks format select).
- LINES=4, SLOT=32: lines carry 0x1111/0x2222/0x3333/0x4444 → four words, line_o 0..3 in order, lr constant per slot.
- ready_i=0 for two slots, LINES=2: overrun_o=1, after ready_i=1 only newest bank words appear; clr_ovr_i clears to 0.
- Final handshake coincident with bank load: overrun_o stays 0, new bank follows seamlessly.
- en_i dropped mid-word, rst_i asserted mid-frame: sclk_o/wsel_o return to 0, no partial word emitted; all outputs at reset values immediately on rst_i.
